fetch_instr_queue: RTL and testbench

Instruction queue between the fetch realigner and the decode stage. Captures each realigned 32-bit instruction word with its PC and a compressed flag into a DEPTH-entry FIFO. Decouples fetch from decode stalls with a valid/ready handshake on both sides. Drops all queued contents on a pipeline flush.

---
 rtl/fetch_instr_queue_if.sv | 23 ++
 rtl/fetch_instr_queue.sv | 56 +++++
 tb/tb_fetch_instr_queue.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fetch_instr_queue_if.sv
// fetch_instr_queue_if: push/pop handshake bundle between fetch realigner, queue and decode.
interface fetch_instr_queue_if #(parameter int DEPTH = 4);
    localparam int CW = $clog2(DEPTH) + 1;
    logic          flush_i;
    logic          valid_i;
    logic [31:0]   instr_i;
    logic [31:0]   pc_i;
    logic          ready_o;
    logic          valid_o;
    logic [31:0]   instr_o;
    logic [31:0]   pc_o;
    logic          is_compressed_o;
    logic          ready_i;
    logic [CW-1:0] count_o;
    modport master (
        output flush_i, valid_i, instr_i, pc_i, ready_i,
        input  ready_o, valid_o, instr_o, pc_o, is_compressed_o, count_o
    );
    modport slave (
        input  flush_i, valid_i, instr_i, pc_i, ready_i,
        output ready_o, valid_o, instr_o, pc_o, is_compressed_o, count_o
    );
endinterface

// File: rtl/fetch_instr_queue.sv
// fetch_instr_queue: DEPTH-entry FIFO of {instr, pc, compressed} between fetch and decode.
// Define FETCH_INSTR_QUEUE_BYPASS_EN for an empty-queue combinational pass-through.
module fetch_instr_queue #(
    parameter int DEPTH = 4
) (
    input logic clk_i,
    input logic rst_i,
    fetch_instr_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [64:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          empty, full, byp, wr_en, rd_en;
    logic [64:0]   in_entry, head;
    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    assign in_entry = {q.instr_i[1:0] != 2'b11, q.pc_i, q.instr_i};
`ifdef FETCH_INSTR_QUEUE_BYPASS_EN
    assign byp = empty && q.valid_i && !q.flush_i;
`else
    assign byp = 1'b0;
`endif
    assign q.ready_o = !full && !q.flush_i;
    assign q.valid_o = (!empty && !q.flush_i) || byp;
    // a bypassed word taken by decode in the same cycle never enters storage
    assign wr_en = q.valid_i && q.ready_o && !(byp && q.ready_i);
    assign rd_en = q.valid_o && q.ready_i && !byp;
    always_comb begin
        head = byp ? in_entry : mem[rd_ptr];
        q.instr_o = q.valid_o ? head[31:0] : 32'h0000_0013;
        q.pc_o = q.valid_o ? head[63:32] : 32'h0;
        q.is_compressed_o = q.valid_o && head[64];
        count_nxt = wr_en && !rd_en ? count + CW'(1) : (rd_en && !wr_en ? count - CW'(1) : count);
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (q.flush_i) begin
            count <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            count <= count_nxt;
            wr_ptr <= wr_ptr + AW'(wr_en);
            rd_ptr <= rd_ptr + AW'(rd_en);
        end
    end
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= in_entry;
    end
    assign q.count_o = count;
endmodule

// File: tb/tb_fetch_instr_queue.sv
// tb_fetch_instr_queue: directed self-checking bench for fetch_instr_queue (DEPTH=4).
module tb_fetch_instr_queue;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int errs = 0;
    int checks = 0;
    logic [31:0] words [4];
    fetch_instr_queue_if #(.DEPTH(4)) bus();
    fetch_instr_queue #(.DEPTH(4)) dut (.clk_i(clk_i), .rst_i(rst_i), .q(bus));
    always #5 clk_i = ~clk_i;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic rdy, input logic fl);
        @(negedge clk_i);
        bus.valid_i = v;
        bus.instr_i = ins;
        bus.pc_i = pc;
        bus.ready_i = rdy;
        bus.flush_i = fl;
        #1;
    endtask
    initial begin
        words[0] = 32'h0000_0013;
        words[1] = 32'h00A0_0093;
        words[2] = 32'h4505_0001;
        words[3] = 32'h00B0_0113;
        bus.valid_i = 0; bus.instr_i = 0; bus.pc_i = 0; bus.ready_i = 0; bus.flush_i = 0;
        #12 rst_i = 1'b0;
        drive(0, 0, 0, 0, 0);
        chk("rst_ready", 32'(bus.ready_o), 1);
        chk("rst_valid", 32'(bus.valid_o), 0);
        chk("rst_instr", bus.instr_o, 32'h13);
        chk("rst_pc", bus.pc_o, 0);
        chk("rst_comp", 32'(bus.is_compressed_o), 0);
        chk("rst_count", 32'(bus.count_o), 0);
        // fill with decode stalled
        for (int i = 0; i < 4; i++) begin
            drive(1, words[i], 32'(4 * i), 0, 0);
            chk($sformatf("fill_count%0d", i), 32'(bus.count_o), 32'(i));
            chk($sformatf("fill_ready%0d", i), 32'(bus.ready_o), 1);
        end
        drive(0, 0, 0, 0, 0);
        chk("full_count", 32'(bus.count_o), 4);
        chk("full_ready", 32'(bus.ready_o), 0);
        chk("full_valid", 32'(bus.valid_o), 1);
        chk("full_comp", 32'(bus.is_compressed_o), 0);
        // drain in order
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 0);
            chk($sformatf("drain_valid%0d", i), 32'(bus.valid_o), 1);
            chk($sformatf("drain_pc%0d", i), bus.pc_o, 32'(4 * i));
            chk($sformatf("drain_instr%0d", i), bus.instr_o, words[i]);
            chk($sformatf("drain_comp%0d", i), 32'(bus.is_compressed_o), (i == 2) ? 1 : 0);
        end
        drive(0, 0, 0, 0, 0);
        chk("empty_valid", 32'(bus.valid_o), 0);
        chk("empty_instr", bus.instr_o, 32'h13);
        chk("empty_count", 32'(bus.count_o), 0);
        // streaming across pointer wrap
        for (int k = 0; k < 12; k++) begin
            drive(1, 32'h0010_0093 + 32'(k << 20), 32'h100 + 32'(4 * k), 1, 0);
`ifdef FETCH_INSTR_QUEUE_BYPASS_EN
            chk($sformatf("stream_pc%0d", k), bus.pc_o, 32'h100 + 32'(4 * k));
            chk($sformatf("stream_count%0d", k), 32'(bus.count_o), 0);
`else
            chk($sformatf("stream_valid%0d", k), 32'(bus.valid_o), (k == 0) ? 0 : 1);
            if (k > 0) begin
                chk($sformatf("stream_pc%0d", k), bus.pc_o, 32'h100 + 32'(4 * (k - 1)));
                chk($sformatf("stream_instr%0d", k), bus.instr_o, 32'h0010_0093 + 32'((k - 1) << 20));
                chk($sformatf("stream_count%0d", k), 32'(bus.count_o), 1);
            end
`endif
        end
`ifndef FETCH_INSTR_QUEUE_BYPASS_EN
        drive(0, 0, 0, 1, 0);
        chk("stream_last_pc", bus.pc_o, 32'h12C);
`endif
        drive(0, 0, 0, 0, 0);
        chk("stream_end_count", 32'(bus.count_o), 0);
        chk("stream_end_valid", 32'(bus.valid_o), 0);
        // flush with a concurrent push
        for (int i = 0; i < 3; i++) drive(1, 32'h0000_0013, 32'h200 + 32'(4 * i), 0, 0);
        drive(1, 32'h0000_0013, 32'h20C, 1, 1);
        chk("flush_count_before", 32'(bus.count_o), 3);
        chk("flush_valid", 32'(bus.valid_o), 0);
        chk("flush_ready", 32'(bus.ready_o), 0);
        chk("flush_instr", bus.instr_o, 32'h13);
        drive(0, 0, 0, 0, 0);
        chk("post_flush_count", 32'(bus.count_o), 0);
        chk("post_flush_valid", 32'(bus.valid_o), 0);
        drive(1, 32'h0040_0093, 32'h300, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("post_flush_head_pc", bus.pc_o, 32'h300);
        chk("post_flush_head_instr", bus.instr_o, 32'h0040_0093);
        chk("post_flush_head_count", 32'(bus.count_o), 1);
        drive(0, 0, 0, 1, 0);
        // async reset between edges
        drive(1, 32'h13, 32'h500, 0, 0);
        drive(1, 32'h13, 32'h504, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("pre_rst_count", 32'(bus.count_o), 2);
        #1 rst_i = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus.valid_o), 0);
        chk("async_rst_count", 32'(bus.count_o), 0);
        chk("async_rst_pc", bus.pc_o, 0);
        rst_i = 1'b0;
        // same-cycle bypass on an empty queue
        drive(1, 32'h0000_4501, 32'h400, 1, 0);
`ifdef FETCH_INSTR_QUEUE_BYPASS_EN
        chk("byp_valid", 32'(bus.valid_o), 1);
        chk("byp_comp", 32'(bus.is_compressed_o), 1);
        chk("byp_instr", bus.instr_o, 32'h0000_4501);
        drive(0, 0, 0, 0, 0);
        chk("byp_count", 32'(bus.count_o), 0);
        chk("byp_after_valid", 32'(bus.valid_o), 0);
`else
        chk("nobyp_valid", 32'(bus.valid_o), 0);
        chk("nobyp_ready", 32'(bus.ready_o), 1);
        drive(0, 0, 0, 0, 0);
        chk("nobyp_next_valid", 32'(bus.valid_o), 1);
        chk("nobyp_next_comp", 32'(bus.is_compressed_o), 1);
        chk("nobyp_next_pc", bus.pc_o, 32'h400);
        chk("nobyp_count", 32'(bus.count_o), 1);
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
